// File: rtl/gf163_reduce_seq_pkg.sv
// -----------------------------------------------------------------------------
// gf163_pkg
// Shared constants, types and helpers for the GF(2^163) reduction stage.
//   f(x) = x^163 + x^7 + x^6 + x^3 + 1
//   GF_M       : field degree (163)
//   GF_PROD_W  : width of an unreduced product (325 bits, deg <= 324)
//   GF_TAPS    : exponents of the low-order terms of f(x)
//   gf_elem_t  : reduced field element
//   gf_prod_t  : unreduced product / accumulator
//   gf_state_t : reduction FSM states (IDLE, FOLD, DONE)
//   nfold()    : fold cycles needed for a given fold width
//   gf_spread(): zero-interleave square of a field element (bit i -> bit 2i)
// -----------------------------------------------------------------------------
package gf163_pkg;

  localparam int GF_M      = 163;
  localparam int GF_PROD_W = 325;

  // Low-order terms of f(x): x^0, x^3, x^6, x^7.
  localparam int               GF_NTAPS = 4;
  localparam logic [3:0][7:0]  GF_TAPS  = {8'd7, 8'd6, 8'd3, 8'd0};

  typedef logic [GF_M-1:0]      gf_elem_t;
  typedef logic [GF_PROD_W-1:0] gf_prod_t;

  // Fold counter width: enough for up to 162 folds (FOLD_W = 1).
  localparam int GF_CNT_W = 8;

  // State encodings kept as plain constants so older code that compares
  // against raw 2-bit values keeps working; the enum mirrors them for debug.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FOLD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FOLD = ST_FOLD,
    DONE = ST_DONE
  } gf_state_t;

  // Bits 324..163 (162 of them) must be folded away, fold_w per cycle.
  function automatic int nfold(input int fold_w);
    return (GF_PROD_W - GF_M + fold_w - 1) / fold_w;
  endfunction

  // Squaring in GF(2)[x] is just spreading the coefficients apart.
  function automatic gf_prod_t gf_spread(input gf_elem_t a);
    gf_prod_t r;
    r = '0;
    for (int i = 0; i < GF_M; i++) begin
      r[2*i] = a[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf163_reduce_seq_if.sv
// -----------------------------------------------------------------------------
// gf163_reduce_seq_if
// Input and output valid/ready streams of the reduction stage.
//   in_valid/in_ready/in_data : unreduced product stream (325 bits)
//   in_sqr                    : squaring request (only with GF_RED_SQR_EN)
//   out_valid/out_ready/out_data : reduced element stream (163 bits)
// Modports:
//   master : the environment (drives products, consumes results)
//   slave  : the reduction stage
// Optional macro: GF_RED_SQR_EN adds in_sqr.
// -----------------------------------------------------------------------------
interface gf163_reduce_seq_if;
  import gf163_pkg::*;

  logic     in_valid;
  logic     in_ready;
  gf_prod_t in_data;
`ifdef GF_RED_SQR_EN
  logic     in_sqr;
`endif
  logic     out_valid;
  logic     out_ready;
  gf_elem_t out_data;

  modport master (
    output in_valid,
    output in_data,
`ifdef GF_RED_SQR_EN
    output in_sqr,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef GF_RED_SQR_EN
    input  in_sqr,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/gf163_reduce_seq_fold_step.sv
// -----------------------------------------------------------------------------
// gf163_fold_step
// Combinational single fold of the reduction accumulator.
//   acc      in  325  current accumulator
//   cnt      in  8    fold index k
//   acc_next out 325  accumulator with chunk k folded down
// Chunk k covers acc[hi:lo], hi = 324 - k*FOLD_W, lo = max(163, hi-FOLD_W+1).
// The chunk is cleared and x^j (j in chunk) is replaced by x^(j-163+t) for
// every tap t of f(x). Because the chunk is isolated by a mask, that is the
// same as XORing the masked chunk shifted right by (163 - t), so the taps
// become fixed shifts and only the mask depends on k.
// -----------------------------------------------------------------------------
module gf163_fold_step
  import gf163_pkg::*;
#(
  parameter int FOLD_W = 54
) (
  input  gf_prod_t              acc,
  input  logic [GF_CNT_W-1:0]   cnt,
  output gf_prod_t              acc_next
);

  int       hi_idx;
  int       lo_idx;
  gf_prod_t chunk_mask;
  gf_prod_t chunk;

  always_comb begin
    hi_idx = GF_PROD_W - 1 - int'(cnt) * FOLD_W;
    lo_idx = hi_idx - FOLD_W + 1;
    if (lo_idx < GF_M) begin
      lo_idx = GF_M;
    end
  end

  // Bits below x^163 are never part of a chunk.
  generate
    for (genvar gi = 0; gi < GF_PROD_W; gi++) begin : g_mask
      if (gi < GF_M) begin : g_low
        assign chunk_mask[gi] = 1'b0;
      end else begin : g_high
        assign chunk_mask[gi] = (gi >= lo_idx) && (gi <= hi_idx);
      end
    end
  endgenerate

  assign chunk = acc & chunk_mask;

  // With FOLD_W <= 156 the highest landing bit (hi-156) is below lo, so the
  // cleared chunk is never re-polluted within the same fold.
  always_comb begin
    acc_next = acc & ~chunk_mask;
    for (int t = 0; t < GF_NTAPS; t++) begin
      acc_next = acc_next ^ (chunk >> (GF_M - int'(GF_TAPS[t])));
    end
  end

endmodule

// File: rtl/gf163_reduce_seq.sv
// -----------------------------------------------------------------------------
// gf163_reduce_seq
// Sequential reduction of a 325-bit GF(2)[x] product modulo
// f(x) = x^163 + x^7 + x^6 + x^3 + 1, folding FOLD_W high bits per cycle.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : gf163_reduce_seq_if.slave (in_valid/in_ready/in_data[/in_sqr],
//          out_valid/out_ready/out_data)
// Parameter FOLD_W (1..156): bits folded per cycle; NFOLD = ceil(162/FOLD_W).
// Timing: accept at edge T, result valid after edge T+NFOLD; a result that is
// taken while a new operand is offered starts the next operand with no bubble.
// Optional macro: GF_RED_SQR_EN -- in_sqr=1 at accept loads the square of
// in_data[162:0] instead of in_data.
// -----------------------------------------------------------------------------
module gf163_reduce_seq
  import gf163_pkg::*;
#(
  parameter int FOLD_W = 54
) (
  input  logic              clk,
  input  logic              rst,
  gf163_reduce_seq_if.slave bus
);

  localparam int                  NFOLD    = nfold(FOLD_W);
  localparam logic [GF_CNT_W-1:0] LAST_CNT = GF_CNT_W'(NFOLD - 1);

  logic [1:0]          state_reg, state_next;
  gf_prod_t            acc_reg, acc_next;
  logic [GF_CNT_W-1:0] cnt_reg, cnt_next;
  logic                out_valid_reg, out_valid_next;
  gf_elem_t            out_data_reg, out_data_next;

  gf_prod_t            fold_acc;
  gf_prod_t            load_acc;
  logic                in_ready;
  logic                accept;

`ifdef GF_RED_SQR_EN
  assign load_acc = bus.in_sqr ? gf_spread(bus.in_data[GF_M-1:0]) : bus.in_data;
`else
  assign load_acc = bus.in_data;
`endif

  // rst gates in_ready directly so it reads 0 throughout reset even though
  // the state register already sits in IDLE.
  assign in_ready = ~rst & ((state_reg == ST_IDLE) |
                            ((state_reg == ST_DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  gf163_fold_step #(
    .FOLD_W (FOLD_W)
  ) u_fold (
    .acc      (acc_reg),
    .cnt      (cnt_reg),
    .acc_next (fold_acc)
  );

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          acc_next   = load_acc;
          cnt_next   = '0;
          state_next = ST_FOLD;
        end
      end
      ST_FOLD: begin
        acc_next = fold_acc;
        cnt_next = cnt_reg + GF_CNT_W'(1);
        if (cnt_reg == LAST_CNT) begin
          state_next     = ST_DONE;
          out_valid_next = 1'b1;
          out_data_next  = fold_acc[GF_M-1:0];
        end
      end
      ST_DONE: begin
        // Result is held until taken; a simultaneous new operand is loaded
        // in the same cycle so back-to-back operands see no idle gap.
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          if (accept) begin
            acc_next   = load_acc;
            cnt_next   = '0;
            state_next = ST_FOLD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

endmodule

// File: tb/tb_gf163_reduce_seq.sv
// -----------------------------------------------------------------------------
// tb_gf163_reduce_seq
// Self-checking bench for gf163_reduce_seq. A directed instance (FOLD_W=54)
// runs a vector table and hand-written handshake/reset sequences; three more
// instances (FOLD_W = 1, 54, 156) take random products in parallel. Expected
// results come from a bit-serial long-division model of mod f(x).
// Optional macro: GF_RED_SQR_EN enables the squaring-mode checks.
// -----------------------------------------------------------------------------
module tb_gf163_reduce_seq;
  import gf163_pkg::*;

  localparam int MAIN_FW    = 54;
  localparam int MAIN_NFOLD = 3;   // 162 high bits in 54-bit chunks

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_sw;

  int n_applied = 0;
  int n_bad     = 0;

  function automatic void check(input string nm, input logic [162:0] act,
                                input logic [162:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic void fail_timeout(input string nm);
    n_applied++;
    n_bad++;
    $display("FAIL %s: got no handshake within bound, expected one", nm);
  endfunction

  // Bit-serial long division by f(x).
  function automatic logic [162:0] ref_reduce(input logic [324:0] c);
    logic [324:0] r;
    logic [324:0] f;
    r = c;
    f = '0;
    f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
    for (int i = 324; i >= 163; i--) begin
      if (r[i]) r = r ^ (f << (i - 163));
    end
    return r[162:0];
  endfunction

  function automatic logic [324:0] ref_square(input logic [162:0] a);
    logic [324:0] s;
    s = '0;
    for (int i = 0; i < 163; i++) s[2*i] = a[i];
    return s;
  endfunction

  function automatic logic [324:0] rand_prod();
    logic [324:0] v;
    v = '0;
    for (int w = 0; w < 11; w++) v = {v[292:0], 32'($urandom)};
    return v;
  endfunction

  // Edges from accept to result valid, accept edge included.
  function automatic int exp_latency(input int fw);
    int rem;
    int k;
    rem = 162;
    k   = 0;
    while (rem > 0) begin
      rem = rem - fw;
      k++;
    end
    return k + 1;
  endfunction

  // ---------------------------------------------------------------- main DUT
  gf163_reduce_seq_if bus ();

  gf163_reduce_seq #(
    .FOLD_W (MAIN_FW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [324:0] data;
    logic [162:0] exp;
  } vec_t;

  vec_t vecs [8];

  // Call at a negedge with nothing in flight; returns at a negedge.
  task automatic run_txn(input logic [324:0] d, input string nm,
                         input logic [162:0] exp);
    int lat;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    lat = 0;
    while (!bus.in_ready && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      fail_timeout({nm, "_accept"});
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      fail_timeout({nm, "_result"});
      return;
    end
    check({nm, "_lat"},  163'(lat), 163'(MAIN_NFOLD + 1));
    check({nm, "_data"}, bus.out_data, exp);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_drop"}, 163'(bus.out_valid), 163'd0);
  endtask

  // Accept d with out_ready low and wait until the result is parked in DONE.
  task automatic park_result(input logic [324:0] d, input string nm);
    int guard;
    bus.out_ready = 1'b0;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.out_valid) fail_timeout(nm);
  endtask

  // -------------------------------------------------------- random sweeps
  localparam int SW_FW  [3] = '{1, 54, 156};
  localparam int SW_CNT [3] = '{150, 1000, 1000};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      gf163_reduce_seq_if sbus ();
      bit done = 1'b0;

      gf163_reduce_seq #(
        .FOLD_W (SW_FW[gi])
      ) u_sw (
        .clk (clk),
        .rst (rst_sw),
        .bus (sbus.slave)
      );

      initial begin
        logic [324:0] d;
        int           guard;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = '0;
        sbus.out_ready = 1'b1;
`ifdef GF_RED_SQR_EN
        sbus.in_sqr    = 1'b0;
`endif
        @(negedge clk);
        while (rst_sw) @(negedge clk);
        for (int n = 0; n < SW_CNT[gi]; n++) begin
          d = rand_prod();
          if (n % 4 == 0) d = 325'd1 << $urandom_range(324, 0);
          sbus.in_data  = d;
          sbus.in_valid = 1'b1;
          guard = 0;
          while (!sbus.in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
          end
          @(posedge clk);
          @(negedge clk);
          sbus.in_valid = 1'b0;
          guard = 1;
          while (!sbus.out_valid && guard < 500) begin
            @(negedge clk);
            guard++;
          end
          if (!sbus.out_valid) begin
            fail_timeout($sformatf("sweep_w%0d_%0d", SW_FW[gi], n));
            break;
          end
          check($sformatf("sweep_w%0d_%0d_lat", SW_FW[gi], n),
                163'(guard), 163'(exp_latency(SW_FW[gi])));
          check($sformatf("sweep_w%0d_%0d_data", SW_FW[gi], n),
                sbus.out_data, ref_reduce(d));
          // Occasional downstream stall before the result is taken.
          if ($urandom_range(3, 0) == 0) begin
            sbus.out_ready = 1'b0;
            @(negedge clk);
            sbus.out_ready = 1'b1;
          end
          @(posedge clk);
          @(negedge clk);
        end
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    rst_sw = 1'b1;
    #25 rst_sw = 1'b0;
  end

  // ------------------------------------------------------- directed tests
  initial begin
    logic [324:0] d;
    logic [324:0] d_b;
    int           cnt_hi;
    int           lat;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef GF_RED_SQR_EN
    bus.in_sqr    = 1'b0;
`endif

    vecs[0].data = 325'd1 << 163;  vecs[0].exp = 163'h0C9;
    vecs[1].data = 325'd1 << 170;  vecs[1].exp = 163'h6480;
    vecs[2].data = 325'd1 << 324;  vecs[2].exp = ref_reduce(325'd1 << 324);
    vecs[3].data = '0;             vecs[3].exp = '0;
    vecs[4].data = {162'd0, {163{1'b1}}};  vecs[4].exp = {163{1'b1}};
    vecs[5].data = {325{1'b1}};    vecs[5].exp = ref_reduce({325{1'b1}});
    vecs[6].data = 325'd1 << 270;  vecs[6].exp = ref_reduce(325'd1 << 270);
    vecs[7].data = 325'd1 << 271;  vecs[7].exp = ref_reduce(325'd1 << 271);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 163'(bus.out_valid), 163'd0);
    check("rst_out_data",  bus.out_data,        163'd0);
    check("rst_in_ready",  163'(bus.in_ready),  163'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 163'(bus.in_ready), 163'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].data, $sformatf("vec%0d", i), vecs[i].exp);
    end

    // Result held while out_ready is low; offered inputs are ignored.
    park_result(325'd1 << 170, "hold_park");
    bus.in_valid = 1'b1;
    bus.in_data  = rand_prod();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold%0d_valid", c),    163'(bus.out_valid), 163'd1);
      check($sformatf("hold%0d_data", c),     bus.out_data,        163'h6480);
      check($sformatf("hold%0d_in_ready", c), 163'(bus.in_ready),  163'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_single_xfer", 163'(bus.out_valid), 163'd0);
    cnt_hi = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) cnt_hi++;
    end
    check("hold_no_dup", 163'(cnt_hi), 163'd0);

    // Result taken and next operand accepted on the same edge.
    d = rand_prod();
    park_result(d, "b2b_park");
    check("b2b_first_data", bus.out_data, ref_reduce(d));
    d_b = rand_prod();
    bus.in_data   = d_b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 163'(bus.in_ready), 163'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_gap_valid", 163'(bus.out_valid), 163'd0);
    lat = 1;
    while (!bus.out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat",  163'(lat), 163'(MAIN_NFOLD + 1));
    check("b2b_data", bus.out_data, ref_reduce(d_b));
    @(posedge clk);
    @(negedge clk);

    // Reset while folding (k=1): clears output at once, nothing stale later.
    run_txn(325'd1 << 163, "pre_rst", 163'h0C9);
    bus.in_data  = rand_prod();
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_fold_out_valid", 163'(bus.out_valid), 163'd0);
    check("rst_fold_out_data",  bus.out_data,        163'd0);
    check("rst_fold_in_ready",  163'(bus.in_ready),  163'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_fold_release_ready", 163'(bus.in_ready), 163'd1);
    cnt_hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) cnt_hi++;
    end
    check("rst_fold_no_stale", 163'(cnt_hi), 163'd0);

    // Reset while a result is parked in DONE.
    park_result(325'd1 << 170, "rst_done_park");
    #2 rst = 1'b1;
    #1;
    check("rst_done_out_valid", 163'(bus.out_valid), 163'd0);
    check("rst_done_out_data",  bus.out_data,        163'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cnt_hi = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) cnt_hi++;
    end
    check("rst_done_no_stale", 163'(cnt_hi), 163'd0);
    run_txn(325'd1 << 170, "post_rst_txn", 163'h6480);

`ifdef GF_RED_SQR_EN
    // Squaring mode: upper input bits must be ignored.
    bus.in_sqr = 1'b1;
    run_txn((325'd1 << 100) | (325'd1 << 300), "sqr_x100", 163'h1920_0000_0000);
    for (int i = 0; i < 8; i++) begin
      d = rand_prod();
      run_txn(d, $sformatf("sqr_rand%0d", i), ref_reduce(ref_square(d[162:0])));
    end
    bus.in_sqr = 1'b0;
    run_txn(325'd1 << 163, "sqr_off", 163'h0C9);
`endif

    // Wait for the random sweeps.
    for (int c = 0; c < 80000; c++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
      @(negedge clk);
    end
    if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done)) begin
      fail_timeout("sweep_finish");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
    $finish;
  end

endmodule
